frame_saver: RTL and testbench

FRAME_SAVER -- requirements
Module: frame_saver

---
 rtl/frame_saver.sv | 147 ++++++++++++++
 tb/tb_frame_saver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_saver.sv
// frame_saver: stores one camera frame into the frame buffer on request from the top controller.
// Optional macro FRAME_SAVER_SUM_EN adds a per-frame unsigned pixel sum on frame_sum.
module frame_saver #(
  parameter int unsigned FRAME_PIXELS = 12288,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_add,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [7:0]        pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              fin_a,
  output logic              frame_err,
  output logic [21:0]       frame_sum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              fin_a_nxt;
  logic              frame_err_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      fin_a     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      fin_a     <= fin_a_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Next state and output values; cnt holds the address of the next pixel in the frame
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    fin_a_nxt     = 1'b0;
    frame_err_nxt = frame_err;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (addr_add) begin
          state_nxt     = WAIT_SOF;
          frame_err_nxt = 1'b0;
        end
      end
      WAIT_SOF: begin
        if (!addr_add) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (pix_valid && pix_sof) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = '0;
          wr_data_nxt = pix_data;
          cnt_nxt     = ADDR_W'(1);
          state_nxt   = CAPTURE;
        end
      end
      CAPTURE: begin
        // Abort beats a pixel arriving in the same cycle
        if (!addr_add) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (pix_valid) begin
          wr_en_nxt   = 1'b1;
          wr_data_nxt = pix_data;
          if (pix_sof) begin
            frame_err_nxt = 1'b1;
            wr_addr_nxt   = '0;
            cnt_nxt       = ADDR_W'(1);
          end else begin
            wr_addr_nxt = cnt;
            if (cnt == LAST_IDX) begin
              state_nxt = DONE;
            end else begin
              cnt_nxt = cnt + ADDR_W'(1);
            end
          end
        end
      end
      DONE: begin
        fin_a_nxt = 1'b1;
        if (!addr_add) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef FRAME_SAVER_SUM_EN
  localparam int unsigned SUM_W = 22;

  logic [SUM_W-1:0] acc;

  // Running sum restarts with every address-0 write; snapshot taken as fin_a rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      if (wr_en_nxt) begin
        acc <= (wr_addr_nxt == '0) ? SUM_W'(wr_data_nxt) : acc + SUM_W'(wr_data_nxt);
      end
      if (fin_a_nxt && !fin_a) begin
        frame_sum <= acc;
      end
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_frame_saver.sv
// Self-checking bench for frame_saver with FRAME_PIXELS=16; expected writes come from a
// frame-position model over the stimulus list.
module tb_frame_saver;
  localparam int unsigned FP = 16;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          addr_add = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [7:0]    pix_data = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          fin_a;
  logic          frame_err;
  logic [21:0]   frame_sum;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int fin_rise_cyc = -1;
  logic fin_q = 1'b0;

  logic [AW+7:0] act_q[$];
  logic [AW+7:0] exp_q[$];
  bit            sv_q[$];
  bit            ss_q[$];
  logic [7:0]    sd_q[$];
  int            exp_sum;
  bit            exp_done;
  bit            exp_err;

  frame_saver #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .addr_add(addr_add), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_data(pix_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .fin_a(fin_a), .frame_err(frame_err), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      act_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
    end
    if (fin_a === 1'b1 && fin_q !== 1'b1) fin_rise_cyc = cyc;
    fin_q = fin_a;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input bit v, input bit s, input logic [7:0] d);
    pix_valid = v; pix_sof = s; pix_data = d;
    tick();
  endtask

  task automatic clear_stim();
    sv_q.delete(); ss_q.delete(); sd_q.delete();
  endtask

  task automatic push(input bit v, input bit s, input logic [7:0] d);
    sv_q.push_back(v); ss_q.push_back(s); sd_q.push_back(d);
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(255));
  endfunction

  // Frame model: position -1 until SOF, each valid pixel takes the next slot, SOF restarts at 0
  function automatic void model();
    int pos = -1;
    int sum = 0;
    exp_q.delete(); exp_done = 0; exp_err = 0;
    foreach (sv_q[i]) begin
      if (!sv_q[i] || exp_done) continue;
      if (ss_q[i]) begin
        if (pos > 0) exp_err = 1;
        pos = 0;
        sum = 0;
      end
      if (pos < 0) continue;
      exp_q.push_back({AW'(pos), sd_q[i]});
      sum += int'(sd_q[i]);
      pos++;
      if (pos == int'(FP)) exp_done = 1;
    end
    exp_sum = sum;
  endfunction

  function automatic logic [21:0] exp_fs();
`ifdef FRAME_SAVER_SUM_EN
    return 22'(exp_sum);
`else
    return 22'd0;
`endif
  endfunction

  // Arm from IDLE, then play the stimulus list with addr_add held
  task automatic run_frame();
    model();
    act_q.delete();
    fin_rise_cyc = -1;
    addr_add = 1'b1;
    set_px(0, 0, 8'h00);
    foreach (sv_q[i]) set_px(sv_q[i], ss_q[i], sd_q[i]);
    repeat (3) set_px(0, 0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr_add = 1'b1;
    set_px(1, 1, rnd8());
    set_px(1, 0, rnd8());
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (fin_a !== 1'b0) begin n_bad++; $display("FAIL reset_fin_a: got %b want 0", fin_a); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (frame_sum !== 22'd0) begin n_bad++; $display("FAIL reset_frame_sum: got %0d want 0", frame_sum); end
    rst_n = 1'b1; addr_add = 1'b0;
    set_px(0, 0, 8'h00);
  endtask

  task automatic test_frame();
    clear_stim();
    push(1, 1, 8'h01);
    for (int i = 2; i <= 16; i++) push(1, 0, 8'(i));
    run_frame();
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL frame_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL frame_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (fin_a !== 1'b1 || fin_rise_cyc != last_wr_cyc + 1) begin n_bad++; $display("FAIL frame_fin: got fin_a=%b rise@%0d want 1 rise@%0d", fin_a, fin_rise_cyc, last_wr_cyc + 1); end
    n_cmp++; if (frame_sum !== exp_fs()) begin n_bad++; $display("FAIL frame_sum: got %0d want %0d", frame_sum, exp_fs()); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL frame_err: got %b want 0", frame_err); end
    addr_add = 1'b0;
    tick(); tick();
    n_cmp++; if (fin_a !== 1'b0) begin n_bad++; $display("FAIL frame_fin_clear: got %b want 0", fin_a); end
  endtask

  task automatic test_gaps();
    clear_stim();
    for (int i = 0; i < 3; i++) begin
      push(1, 0, rnd8());
      push(0, 1'($urandom_range(1)), rnd8());
    end
    push(1, 1, rnd8());
    for (int i = 1; i < int'(FP); i++) begin
      push(0, 1'($urandom_range(1)), rnd8());
      push(1, 0, rnd8());
    end
    run_frame();
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gaps_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gaps_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (fin_a !== 1'b1 || fin_rise_cyc != last_wr_cyc + 1) begin n_bad++; $display("FAIL gaps_fin: got fin_a=%b rise@%0d want 1 rise@%0d", fin_a, fin_rise_cyc, last_wr_cyc + 1); end
    n_cmp++; if (frame_sum !== exp_fs()) begin n_bad++; $display("FAIL gaps_sum: got %0d want %0d", frame_sum, exp_fs()); end
    addr_add = 1'b0;
    tick(); tick();
  endtask

  task automatic test_abort();
    clear_stim();
    push(1, 1, rnd8());
    for (int i = 1; i < 7; i++) push(1, 0, rnd8());
    run_frame();
    addr_add = 1'b0;
    set_px(1, 0, rnd8());
    repeat (3) set_px(0, 0, 8'h00);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL abort_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (fin_rise_cyc != -1 || fin_a !== 1'b0) begin n_bad++; $display("FAIL abort_fin: got fin_a=%b rise@%0d want 0 no rise", fin_a, fin_rise_cyc); end
    clear_stim();
    push(1, 1, rnd8());
    for (int i = 1; i < int'(FP); i++) push(1, 0, rnd8());
    run_frame();
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL after_abort_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL after_abort_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (frame_sum !== exp_fs()) begin n_bad++; $display("FAIL after_abort_sum: got %0d want %0d", frame_sum, exp_fs()); end
    addr_add = 1'b0;
    tick(); tick();
  endtask

  // Leaves the FSM in DONE with addr_add held for test_done_hold
  task automatic test_restart();
    clear_stim();
    push(1, 1, rnd8());
    for (int i = 1; i < 8; i++) push(1, 0, rnd8());
    push(1, 1, rnd8());
    for (int i = 1; i < int'(FP); i++) push(1, 0, rnd8());
    run_frame();
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL restart_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL restart_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (frame_err !== 1'(exp_err)) begin n_bad++; $display("FAIL restart_err: got %b want %b", frame_err, exp_err); end
    n_cmp++; if (fin_a !== 1'b1 || fin_rise_cyc != last_wr_cyc + 1) begin n_bad++; $display("FAIL restart_fin: got fin_a=%b rise@%0d want 1 rise@%0d", fin_a, fin_rise_cyc, last_wr_cyc + 1); end
    n_cmp++; if (frame_sum !== exp_fs()) begin n_bad++; $display("FAIL restart_sum: got %0d want %0d", frame_sum, exp_fs()); end
  endtask

  task automatic test_done_hold();
    act_q.delete();
    for (int i = 0; i < 6; i++) set_px(1, 1'($urandom_range(1)), rnd8());
    set_px(0, 0, 8'h00);
    n_cmp++; if (act_q.size() != 0) begin n_bad++; $display("FAIL done_writes: got %0d want 0", act_q.size()); end
    n_cmp++; if (fin_a !== 1'b1) begin n_bad++; $display("FAIL done_fin_hold: got %b want 1", fin_a); end
    addr_add = 1'b0;
    tick(); tick();
    n_cmp++; if (fin_a !== 1'b0) begin n_bad++; $display("FAIL done_fin_clear: got %b want 0", fin_a); end
    n_cmp++; if (frame_sum !== exp_fs()) begin n_bad++; $display("FAIL done_sum_hold: got %0d want %0d", frame_sum, exp_fs()); end
  endtask

  task automatic test_err_clear();
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", frame_err); end
    addr_add = 1'b1;
    tick();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_arm: got %b want 0", frame_err); end
    addr_add = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    addr_add = 1'b1;
    set_px(0, 0, 8'h00);
    set_px(1, 1, rnd8());
    set_px(1, 0, rnd8());
    set_px(1, 1, rnd8());
    set_px(1, 0, rnd8());
    rst_n = 1'b0;
    set_px(1, 0, rnd8());
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL mid_reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL mid_reset_wr_addr: got %h want 0", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL mid_reset_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (frame_sum !== 22'd0) begin n_bad++; $display("FAIL mid_reset_frame_sum: got %0d want 0", frame_sum); end
    rst_n = 1'b1;
    act_q.delete();
    for (int i = 0; i < 5; i++) set_px(1, 0, rnd8());
    repeat (2) set_px(0, 0, 8'h00);
    n_cmp++; if (act_q.size() != 0) begin n_bad++; $display("FAIL mid_reset_no_sof_writes: got %0d want 0", act_q.size()); end
    n_cmp++; if (fin_a !== 1'b0) begin n_bad++; $display("FAIL mid_reset_fin: got %b want 0", fin_a); end
    addr_add = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_abort();
    test_restart();
    test_done_hold();
    test_err_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
